// File: rtl/multicycle_controller.sv
// Main FSM of the multicycle MIPS core: sequences FETCH..WB states over the shared datapath.
// Optional BNE support is enabled by defining MULTICYCLE_BNE_EN.
module multicycle_controller #(
   parameter int         CNT_W    = 32,
   parameter logic [5:0] OP_RTYPE = 6'h00,
   parameter logic [5:0] OP_LW    = 6'h23,
   parameter logic [5:0] OP_SW    = 6'h2B,
   parameter logic [5:0] OP_BEQ   = 6'h04,
   parameter logic [5:0] OP_ADDI  = 6'h08,
   parameter logic [5:0] OP_J     = 6'h02
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [5:0]       Op,
   input  logic             Zero,
   input  logic             MemReady,
   output logic             IorD,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSrc,
   output logic             PCEn,
   output logic             IllegalOp,
   output logic [CNT_W-1:0] InstrCount,
   output logic [3:0]       State
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMRD    = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWR    = 4'd5;
   localparam logic [3:0] S_EXECUTE  = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_BRANCH   = 4'd8;
   localparam logic [3:0] S_ADDIEXEC = 4'd9;
   localparam logic [3:0] S_ADDIWB   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;
`ifdef MULTICYCLE_BNE_EN
   localparam logic [3:0] S_BNE      = 4'd12;
   localparam logic [5:0] OP_BNE     = 6'h05;
`endif

   logic [3:0]       r_state;
   logic [CNT_W-1:0] r_count;
   logic [3:0]       w_next;
   logic             w_retire;
   logic             w_illegal;
   logic             w_memwrite;
   logic             w_irwrite;
   logic             w_regwrite;
   logic             w_pcen;

   // Next-state selection, retirement and illegal-opcode detection
   always_comb begin
      w_next    = S_FETCH;
      w_retire  = 1'b0;
      w_illegal = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (MemReady) w_next = S_DECODE;
            else          w_next = S_FETCH;
         end
         S_DECODE: begin
            if ((Op == OP_LW) || (Op == OP_SW)) w_next = S_MEMADR;
            else if (Op == OP_RTYPE)            w_next = S_EXECUTE;
            else if (Op == OP_BEQ)              w_next = S_BRANCH;
            else if (Op == OP_ADDI)             w_next = S_ADDIEXEC;
            else if (Op == OP_J)                w_next = S_JUMP;
`ifdef MULTICYCLE_BNE_EN
            else if (Op == OP_BNE)              w_next = S_BNE;
`endif
            else begin
               w_next    = S_FETCH;
               w_illegal = 1'b1;
            end
         end
         S_MEMADR: begin
            if (Op == OP_LW)      w_next = S_MEMRD;
            else if (Op == OP_SW) w_next = S_MEMWR;
            else                  w_next = S_FETCH;
         end
         S_MEMRD: begin
            if (MemReady) w_next = S_MEMWB;
            else          w_next = S_MEMRD;
         end
         S_MEMWB: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         // The store strobe stays up until memory accepts it; only then does it retire
         S_MEMWR: begin
            if (MemReady) begin
               w_next   = S_FETCH;
               w_retire = 1'b1;
            end else begin
               w_next   = S_MEMWR;
            end
         end
         S_EXECUTE:  w_next = S_ALUWB;
         S_ALUWB: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         S_BRANCH: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         S_ADDIEXEC: w_next = S_ADDIWB;
         S_ADDIWB: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         S_JUMP: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
`ifdef MULTICYCLE_BNE_EN
         S_BNE: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
`endif
         default: w_next = S_FETCH;
      endcase
   end

   // Moore control decode from the current state
   always_comb begin
      IorD       = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      w_regwrite = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      PCSrc      = 2'b00;
      w_pcen     = 1'b0;
      case (r_state)
         S_FETCH: begin
            ALUSrcB   = 2'b01;
            w_irwrite = MemReady;
            w_pcen    = MemReady;
         end
         S_DECODE: ALUSrcB = 2'b11;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: IorD = 1'b1;
         S_MEMWB: begin
            MemtoReg   = 1'b1;
            w_regwrite = 1'b1;
         end
         S_MEMWR: begin
            IorD       = 1'b1;
            w_memwrite = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         S_ALUWB: begin
            RegDst     = 1'b1;
            w_regwrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b01;
            PCSrc   = 2'b01;
            w_pcen  = Zero;
         end
         S_ADDIEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDIWB: w_regwrite = 1'b1;
         S_JUMP: begin
            PCSrc  = 2'b10;
            w_pcen = 1'b1;
         end
`ifdef MULTICYCLE_BNE_EN
         S_BNE: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b01;
            PCSrc   = 2'b01;
            w_pcen  = ~Zero;
         end
`endif
         default: ALUSrcB = 2'b00;
      endcase
   end

   // Enables are forced low for the whole time reset is asserted, not just after the next edge
   assign MemWrite   = w_memwrite & reset_n;
   assign IRWrite    = w_irwrite  & reset_n;
   assign RegWrite   = w_regwrite & reset_n;
   assign PCEn       = w_pcen     & reset_n;
   assign IllegalOp  = w_illegal  & reset_n;
   assign State      = r_state;
   assign InstrCount = r_count;

   // State register and retired-instruction counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_FETCH;
         r_count <= {CNT_W{1'b0}};
      end else begin
         r_state <= w_next;
         if (w_retire) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
